// File: rtl/sinx_pkg.sv
// sinx_pkg: shared constants and types for the sine-core arbiter.
// Q16.16 data format, FSM state encoding, id and counter widths.
package sinx_pkg;

   localparam int DATA_W = 32;
   localparam int FRAC_W = 16;
   localparam int ID_W   = 3;
   localparam int CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/sinx_core_arbiter_if.sv
// sinx_core_arbiter_if: requester, core and response channels.
// master = arbiter side, slave = clients/core/consumer side.
interface sinx_core_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32
);
   import sinx_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_x;
   logic [NUM_REQ-1:0]        req_ready;

   logic [DATA_W-1:0]         core_x;
   logic                      core_start;
   logic [DATA_W-1:0]         core_y;
   logic                      core_sign;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_W-1:0]         rsp_y;
   logic                      rsp_sign;
   logic [ID_W-1:0]           rsp_id;

   modport master (
      input  req_valid, req_x, core_y, core_sign, rsp_ready,
      output req_ready, core_x, core_start,
      output rsp_valid, rsp_y, rsp_sign, rsp_id
   );

   modport slave (
      output req_valid, req_x, core_y, core_sign, rsp_ready,
      input  req_ready, core_x, core_start,
      input  rsp_valid, rsp_y, rsp_sign, rsp_id
   );

endinterface

// File: rtl/sinx_rr_grant.sv
// sinx_rr_grant: combinational winner select over the request vector.
// SINX_ARB_FIXED_PRIO_EN selects lowest-index priority instead of round-robin.
module sinx_rr_grant
   import sinx_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [ID_W-1:0]    grant,
   output logic               any
);

`ifdef SINX_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last;

   // lowest set index wins; scan downward so the last hit is the lowest
   always_comb begin
      grant = '0;
      any   = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant = ID_W'(i);
            any   = 1'b1;
         end
      end
   end
`else
   int best;
   int d;

   // winner is the valid requester at the smallest distance past last
   always_comb begin
      grant = '0;
      any   = 1'b0;
      best  = NUM_REQ;
      d     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         d = (i + NUM_REQ - 1 - int'(last)) % NUM_REQ;
         if (req[i] && d < best) begin
            best  = d;
            grant = ID_W'(i);
            any   = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/sinx_core_arbiter.sv
// sinx_core_arbiter: shares one sine core among NUM_REQ requesters.
// SINX_ARB_FIXED_PRIO_EN drops the round-robin pointer for fixed priority.
module sinx_core_arbiter
   import sinx_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 32,
   parameter int CORE_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   sinx_core_arbiter_if.master bus
);

   state_t              state;
   logic [ID_W-1:0]     last;
   logic [ID_W-1:0]     grant;
   logic                any;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   sel_x;
   logic [NUM_REQ-1:0]  gnt_oh;

   sinx_rr_grant #(
      .NUM_REQ (NUM_REQ)
   ) u_grant (
      .req   (bus.req_valid),
      .last  (last),
      .grant (grant),
      .any   (any)
   );

   // operand mux and one-hot accept for the current winner
   always_comb begin
      sel_x  = '0;
      gnt_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_x     = bus.req_x[i*DATA_W +: DATA_W];
            gnt_oh[i] = 1'b1;
         end
      end
   end

`ifdef SINX_ARB_FIXED_PRIO_EN
   assign last = ID_W'(NUM_REQ - 1);
`else
   // remember the last winner so the search starts just past it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= ID_W'(NUM_REQ - 1);
      end else if (state == IDLE && any) begin
         last <= grant;
      end
   end
`endif

   // issue / wait-for-core / respond sequencer with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.req_ready  <= '0;
         bus.core_x     <= '0;
         bus.core_start <= 1'b0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_y      <= '0;
         bus.rsp_sign   <= 1'b0;
         bus.rsp_id     <= '0;
      end else begin
         bus.req_ready  <= '0;
         bus.core_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any) begin
                  bus.req_ready  <= gnt_oh;
                  bus.core_x     <= sel_x;
                  bus.core_start <= 1'b1;
                  bus.rsp_id     <= grant;
                  cnt            <= CNT_W'(CORE_LAT);
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  bus.rsp_y     <= bus.core_y;
                  bus.rsp_sign  <= bus.core_sign;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sinx_core_arbiter.sv
// tb_sinx_core_arbiter: scoreboard bench with a core stub and an
// arbitration reference model; honours SINX_ARB_FIXED_PRIO_EN.
module tb_sinx_core_arbiter;
   import sinx_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int L  = 1;

   localparam int M_IDLE = 0;
   localparam int M_BUSY = 1;
   localparam int M_GAP  = 2;

   typedef struct packed {
      logic [2:0]    id;
      logic [DW-1:0] y;
      logic          s;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nvec = 0;
   int   nerr = 0;

   exp_t sb[$];
   int   idlog[$];

   sinx_core_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

   sinx_core_arbiter #(
      .NUM_REQ  (N),
      .DATA_W   (DW),
      .CORE_LAT (L)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // core stub: y = ~x, sign = x[0], L registers deep
   logic [DW-1:0] ypipe [L];
   logic          spipe [L];
   always @(posedge clk) begin
      ypipe[0] <= ~bus.core_x;
      spipe[0] <= bus.core_x[0];
      for (int k = 1; k < L; k++) begin
         ypipe[k] <= ypipe[k-1];
         spipe[k] <= spipe[k-1];
      end
   end
   assign bus.core_y    = ypipe[L-1];
   assign bus.core_sign = spipe[L-1];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // who should win, from the valid set and the previous winner
   function automatic int pick(input logic [N-1:0] v, input int prev);
`ifdef SINX_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++)
         if (v[k]) return k;
`else
      for (int k = 1; k <= N; k++)
         if (v[(prev + k) % N]) return (prev + k) % N;
`endif
      return -1;
   endfunction

   // reference model: predicts grants, timing, and pushes expectations
   int               m_st = M_GAP;
   int               m_last = N - 1;
   int               m_cnt = 0;
   int               w;
   logic [DW-1:0]    m_x;
   logic [N-1:0]     pv = '0;
   logic [N*DW-1:0]  px = '0;
   logic [N-1:0]     a_rdy = '0;
   logic [N-1:0]     oh;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_st   = M_GAP;
         m_last = N - 1;
         pv     = '0;
         a_rdy  = '0;
      end else begin
         case (m_st)
            M_IDLE: begin
               if (|pv) begin
                  w  = pick(pv, m_last);
                  oh = '0;
                  oh[w] = 1'b1;
                  m_x = px[w*DW +: DW];
                  chk("grant", bus.req_ready, oh);
                  chk("core_x", bus.core_x, m_x);
                  chk("core_start", bus.core_start, 1);
                  sb.push_back('{id: 3'(w), y: ~m_x, s: m_x[0]});
                  m_last = w;
                  m_cnt  = 0;
                  m_st   = M_BUSY;
               end else begin
                  chk("idle_out",
                      {bus.req_ready, bus.core_start, bus.rsp_valid}, 0);
               end
            end
            M_BUSY: begin
               m_cnt++;
               chk("busy_ready", {bus.req_ready, bus.core_start}, 0);
               chk("core_x_hold", bus.core_x, m_x);
               chk("rsp_timing", bus.rsp_valid, m_cnt >= L + 1);
               if (bus.rsp_valid && bus.rsp_ready) m_st = M_GAP;
            end
            default: begin
               chk("gap_out", {bus.req_ready, bus.rsp_valid}, 0);
               m_st = M_IDLE;
            end
         endcase
         pv    = bus.req_valid;
         px    = bus.req_x;
         a_rdy = bus.req_ready;
      end
   end

   // response monitor: pops and compares on every response transfer
   logic          held = 1'b0;
   logic [DW-1:0] hy;
   logic          hs;
   logic [2:0]    hid;
   exp_t          e;

   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid", bus.rsp_valid, 1);
            chk("stall_data", {bus.rsp_id, bus.rsp_sign, bus.rsp_y},
                {hid, hs, hy});
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_rsp", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rsp_id", bus.rsp_id, e.id);
               chk("rsp_y", bus.rsp_y, e.y);
               chk("rsp_sign", bus.rsp_sign, e.s);
            end
            idlog.push_back(int'(bus.rsp_id));
         end
         held = bus.rsp_valid && !bus.rsp_ready;
         hy   = bus.rsp_y;
         hs   = bus.rsp_sign;
         hid  = bus.rsp_id;
      end
   end

   // mode 0 hold, 1 renew x on transfer, 2 drop on transfer, 3 random
   task automatic drive_step(input int mode);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         logic done;
         done = bus.req_valid[i] && a_rdy[i];
         case (mode)
            1: if (done) bus.req_x[i*DW +: DW] = $urandom;
            2: if (done) bus.req_valid[i] = 1'b0;
            3: begin
               if (done) begin
                  bus.req_valid[i] = 1'($urandom_range(0, 1));
                  bus.req_x[i*DW +: DW] = $urandom;
               end else if (!bus.req_valid[i]) begin
                  if ($urandom_range(0, 2) == 0) begin
                     bus.req_valid[i] = 1'b1;
                     bus.req_x[i*DW +: DW] = $urandom;
                  end
               end else if (!a_rdy[i] && $urandom_range(0, 15) == 0) begin
                  bus.req_valid[i] = 1'b0;
               end
            end
            default: ;
         endcase
      end
      if (mode == 3) bus.rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic run_until(input int mode, input int target,
                            input int budget);
      int t;
      t = 0;
      while (idlog.size() < target && t < budget) begin
         drive_step(mode);
         t++;
      end
   endtask

   task automatic wait_grant(input string nm, input logic [N-1:0] exp);
      int t;
      t = 0;
      while (t < 30) begin
         @(negedge clk);
         #1;
         if (bus.req_ready != '0) break;
         t++;
      end
      chk(nm, bus.req_ready, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int t;
      logic [DW-1:0] sy;
      logic          ss;
      logic [2:0]    sid;

      bus.rsp_ready = 1'b1;
      bus.req_valid = '1;
      for (int i = 0; i < N; i++) bus.req_x[i*DW +: DW] = $urandom;
      rst_n = 1'b0;

      repeat (3) begin
         @(negedge clk);
         chk("reset_ctl", {bus.req_ready, bus.core_start, bus.rsp_valid,
                           bus.rsp_sign, bus.rsp_id}, 0);
         chk("reset_core_x", bus.core_x, 0);
         chk("reset_rsp_y", bus.rsp_y, 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      wait_grant("first_grant", 4'b0001);

      base = idlog.size();
      run_until(1, base + 8, 200);
      for (int k = 0; k < 8; k++) begin
`ifdef SINX_ARB_FIXED_PRIO_EN
         chk("prio_seq", idlog.size() > base + k ? idlog[base+k] : 7, 0);
`else
         chk("rr_seq", idlog.size() > base + k ? idlog[base+k] : 7, k % N);
`endif
      end

      @(posedge clk);
      #1 bus.req_valid = '0;
      repeat (10) drive_step(0);

      @(posedge clk);
      #1;
      bus.req_x[2*DW +: DW] = 32'h0000_8001;
      bus.req_valid = 4'b0100;
      wait_grant("single_grant", 4'b0100);
      chk("single_core_x", bus.core_x, 32'h0000_8001);
      chk("single_start", bus.core_start, 1);
      t = 0;
      while (t < 20) begin
         @(negedge clk);
         t++;
         if (t == 1) #1 bus.req_valid[2] = 1'b0;
         if (bus.rsp_valid) break;
      end
      chk("single_latency", t, L + 1);
      chk("single_y", bus.rsp_y, 32'hFFFF_7FFE);
      chk("single_sign", bus.rsp_sign, 1);
      chk("single_id", bus.rsp_id, 2);
      repeat (4) drive_step(0);

      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      bus.req_x[1*DW +: DW] = $urandom;
      bus.req_valid = 4'b0010;
      wait_grant("stall_grant", 4'b0010);
      #1 bus.req_valid = 4'b1111;
      t = 0;
      while (t < 20 && !bus.rsp_valid) begin
         @(negedge clk);
         t++;
      end
      chk("stall_rsp_seen", bus.rsp_valid, 1);
      sy   = bus.rsp_y;
      ss   = bus.rsp_sign;
      sid  = bus.rsp_id;
      base = idlog.size();
      repeat (5) begin
         @(negedge clk);
         chk("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_sign,
                            bus.rsp_y}, {1'b1, sid, ss, sy});
         chk("stall_no_ready", bus.req_ready, 0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall_pre_xfer", bus.rsp_valid, 1);
      @(negedge clk);
      chk("stall_post_xfer", bus.rsp_valid, 0);
      chk("stall_one_xfer", idlog.size(), base + 1);

      t = 0;
      while (t < 30) begin
         @(negedge clk);
         t++;
         if (bus.req_ready != '0) break;
      end
      #2 rst_n = 1'b0;
      base = idlog.size();
      repeat (2) begin
         @(negedge clk);
         chk("midwait_reset", {bus.rsp_valid, bus.req_ready}, 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_grant("post_reset_grant", 4'b0001);
      chk("midwait_no_rsp", idlog.size(), base);

      repeat (1500) drive_step(3);

      @(posedge clk);
      #1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (20) drive_step(0);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
